// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared state encoding, grant IDs and defaults for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY_I = 2'b01,
    ARB_BUSY_D = 2'b10
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr2
// Brief    : Combinational two-way round-robin picker (icache vs dcache).
// Revision : 1.0 - initial release
// ============================================================================
module arb_rr2
  import mem_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic grant,
  output logic any
);

  assign any = req_i | req_d;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant = GNT_I;
    if (req_i && req_d) begin
      grant = (last_grant == GNT_D) ? GNT_I : GNT_D;
    end else if (req_d) begin
      grant = GNT_D;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin sharing of the main-memory port between the icache
//            refill path and the dcache, with per-transaction watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                c_CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

  arb_state_t          r_state, w_state_nxt;
  logic                r_last_grant, w_last_grant_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic                w_grant, w_any, w_expired;
  logic                w_mem_req_nxt, w_mem_we_nxt;
  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   w_mem_wdata_nxt, w_i_rdata_nxt, w_d_rdata_nxt;
  logic                w_i_ack_nxt, w_i_err_nxt, w_d_ack_nxt, w_d_err_nxt;

  arb_rr2 u_rr2 (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .any        (w_any)
  );

  assign w_expired = (r_cnt == c_CNT_MAX);

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_mem_req_nxt    = mem_req;
    w_mem_we_nxt     = mem_we;
    w_mem_addr_nxt   = mem_addr;
    w_mem_wdata_nxt  = mem_wdata;
    w_i_ack_nxt      = 1'b0;
    w_i_err_nxt      = 1'b0;
    w_i_rdata_nxt    = '0;
    w_d_ack_nxt      = 1'b0;
    w_d_err_nxt      = 1'b0;
    w_d_rdata_nxt    = '0;

    case (r_state)
      ARB_IDLE: begin
        // mem_ack is deliberately ignored here: a stray ack has no owner.
        if (w_any) begin
          w_last_grant_nxt = w_grant;
          w_cnt_nxt        = '0;
          w_mem_req_nxt    = 1'b1;
          if (w_grant == GNT_D) begin
            w_state_nxt     = ARB_BUSY_D;
            w_mem_we_nxt    = d_we;
            w_mem_addr_nxt  = d_addr;
            w_mem_wdata_nxt = d_wdata;
          end else begin
            w_state_nxt     = ARB_BUSY_I;
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = i_addr;
            w_mem_wdata_nxt = '0;
          end
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        // A real ack arriving on the expiry cycle takes precedence.
        if (mem_ack || w_expired) begin
          w_state_nxt   = ARB_IDLE;
          w_mem_req_nxt = 1'b0;
          if (r_state == ARB_BUSY_I) begin
            w_i_ack_nxt   = 1'b1;
            w_i_err_nxt   = ~mem_ack;
            w_i_rdata_nxt = mem_ack ? mem_rdata : '0;
          end else begin
            w_d_ack_nxt   = 1'b1;
            w_d_err_nxt   = ~mem_ack;
            w_d_rdata_nxt = (mem_ack && !mem_we) ? mem_rdata : '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= GNT_D;
      r_cnt        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_ack        <= 1'b0;
      i_err        <= 1'b0;
      i_rdata      <= '0;
      d_ack        <= 1'b0;
      d_err        <= 1'b0;
      d_rdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      mem_req      <= w_mem_req_nxt;
      mem_we       <= w_mem_we_nxt;
      mem_addr     <= w_mem_addr_nxt;
      mem_wdata    <= w_mem_wdata_nxt;
      i_ack        <= w_i_ack_nxt;
      i_err        <= w_i_err_nxt;
      i_rdata      <= w_i_rdata_nxt;
      d_ack        <= w_d_ack_nxt;
      d_err        <= w_d_err_nxt;
      d_rdata      <= w_d_rdata_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter with a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk, rst;
  logic          i_req, i_ack, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ack, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int            m_owner;     // 0 none, 1 icache, 2 dcache
  int            m_age;       // edges elapsed since the memory request rose
  bit            m_last_d;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            m_we;
  bit            e_iack, e_ierr, e_dack, e_derr;
  logic [DW-1:0] e_irdata, e_drdata;

  initial forever begin
    @(posedge clk or posedge rst);
    e_iack = 0; e_ierr = 0; e_dack = 0; e_derr = 0; e_irdata = '0; e_drdata = '0;
    if (rst) begin
      m_owner = 0; m_age = 0; m_last_d = 1; m_addr = '0; m_wdata = '0; m_we = 0;
    end else if (m_owner != 0) begin
      m_age++;
      if (mem_ack || m_age == TO) begin
        if (m_owner == 1) begin
          e_iack = 1; e_ierr = !mem_ack; e_irdata = mem_ack ? mem_rdata : '0;
        end else begin
          e_dack = 1; e_derr = !mem_ack; e_drdata = (mem_ack && !m_we) ? mem_rdata : '0;
        end
        m_owner = 0;
      end
    end else if (i_req || d_req) begin
      bit win_d;
      win_d    = d_req && (!i_req || !m_last_d);
      m_last_d = win_d;
      m_owner  = win_d ? 2 : 1;
      m_age    = 0;
      m_addr   = win_d ? d_addr : i_addr;
      m_we     = win_d && d_we;
      m_wdata  = win_d ? d_wdata : '0;
    end
  end

  // ---------------- compare process ----------------
  logic [AW-1:0] grants_q[$];
  bit            prev_req = 0;

  initial forever begin
    @(negedge clk);
    chk("mem_req", {63'd0, mem_req}, {63'd0, m_owner != 0});
    chk("i_ack",   {63'd0, i_ack},   {63'd0, e_iack});
    chk("d_ack",   {63'd0, d_ack},   {63'd0, e_dack});
    chk("i_err",   {63'd0, i_err},   {63'd0, e_ierr});
    chk("d_err",   {63'd0, d_err},   {63'd0, e_derr});
    if (m_owner != 0) begin
      chk("mem_addr",  {32'd0, mem_addr},  {32'd0, m_addr});
      chk("mem_we",    {63'd0, mem_we},    {63'd0, m_we});
      chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, m_wdata});
    end
    if (e_iack) chk("i_rdata", {32'd0, i_rdata}, {32'd0, e_irdata});
    if (e_dack) chk("d_rdata", {32'd0, d_rdata}, {32'd0, e_drdata});
    if (mem_req && !prev_req) grants_q.push_back(mem_addr);
    prev_req = mem_req;
  end

  // ---------------- stimulus ----------------
  int            mode_i, mode_d;   // 0 manual, 1 drop at ack, 2 reissue after ack
  bit            lat_en;
  int            mem_lat, wait_cnt, cyc;
  logic [DW-1:0] rdata_val;

  // One clock: responder and requester behaviour applied 1 time unit after the edge.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    mem_ack = 1'b0;
    if (rst || !mem_req) wait_cnt = 0;
    else if (lat_en) begin
      if (wait_cnt == mem_lat) begin
        mem_ack = 1'b1; mem_rdata = rdata_val; wait_cnt = 0;
      end else wait_cnt++;
    end
    if (mode_i != 0) begin
      if (i_ack) begin i_req = 1'b0; if (mode_i == 1) mode_i = 0; end
      else if (mode_i == 2) i_req = 1'b1;
    end
    if (mode_d != 0) begin
      if (d_ack) begin d_req = 1'b0; if (mode_d == 1) mode_d = 0; end
      else if (mode_d == 2) d_req = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit side_d, input int budget, input string name);
    int n = 0;
    do begin step(); n++; end
    while (!(side_d ? d_ack : i_ack) && n < budget);
    if (!(side_d ? d_ack : i_ack)) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  initial begin
    int t_rise, t_ack;
    rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0; mode_i = 0; mode_d = 0; lat_en = 0; mem_lat = 0;
    wait_cnt = 0; cyc = 0; rdata_val = '0;
    step(); step();
    chk("reset_mem_req", {63'd0, mem_req}, 64'd0);
    chk("reset_acks", {62'd0, i_ack, d_ack}, 64'd0);
    rst = 1'b0;
    step();

    // icache miss alone, memory acks after 3 cycles
    i_addr = 32'h0000_4000; i_req = 1; mode_i = 1;
    lat_en = 1; mem_lat = 3; rdata_val = 32'hDEAD_BEEF;
    step();
    chk("t1_mem_req_next", {63'd0, mem_req}, 64'd1);
    chk("t1_mem_addr", {32'd0, mem_addr}, 64'h4000);
    wait_ack(0, 20, "t1");
    chk("t1_rdata", {32'd0, i_rdata}, 64'hDEAD_BEEF);
    chk("t1_err", {63'd0, i_err}, 64'd0);
    step(); step();

    // simultaneous requests after reset: icache first, then dcache write
    do_reset();
    grants_q.delete();
    i_addr = 32'h1000; i_req = 1; mode_i = 1;
    d_addr = 32'h100; d_we = 1; d_wdata = 32'h1234_5678; d_req = 1; mode_d = 1;
    mem_lat = 1; rdata_val = 32'hAAAA_5555;
    wait_ack(1, 40, "t2");
    chk("t2_d_rdata", {32'd0, d_rdata}, 64'd0);
    chk("t2_d_err", {63'd0, d_err}, 64'd0);
    chk("t2_ngrants", grants_q.size(), 64'd2);
    if (grants_q.size() >= 2) begin
      chk("t2_first_i", {32'd0, grants_q[0]}, 64'h1000);
      chk("t2_then_d", {32'd0, grants_q[1]}, 64'h100);
    end
    step(); step();

    // fairness: both reissue right after each ack
    grants_q.delete();
    d_we = 0; d_addr = 32'h2000; mem_lat = 0;
    i_req = 1; d_req = 1; mode_i = 2; mode_d = 2;
    for (int n = 0; n < 100 && grants_q.size() < 6; n++) step();
    mode_i = 1; mode_d = 1;
    repeat (30) step();
    chk("t3_ngrants_ge6", {63'd0, grants_q.size() >= 6}, 64'd1);
    for (int k = 0; k < 6 && k < grants_q.size(); k++)
      chk("t3_alternate", {32'd0, grants_q[k]}, (k % 2 == 0) ? 64'h1000 : 64'h2000);

    // watchdog: memory never acks a dcache read
    lat_en = 0; d_addr = 32'h300; d_req = 1; mode_d = 1;
    t_rise = -1; t_ack = -1;
    for (int n = 0; n < 40 && t_ack < 0; n++) begin
      step();
      if (mem_req && t_rise < 0) t_rise = cyc;
      if (d_ack) t_ack = cyc;
    end
    chk("t4_ack_seen", {63'd0, t_ack >= 0}, 64'd1);
    chk("t4_latency", 64'(t_ack - t_rise), 64'd8);
    chk("t4_err", {63'd0, d_err}, 64'd1);
    chk("t4_rdata", {32'd0, d_rdata}, 64'd0);
    chk("t4_mem_req_low", {63'd0, mem_req}, 64'd0);
    step(); step();

    // mem_ack on the expiry cycle wins
    lat_en = 1; mem_lat = TO - 1; rdata_val = 32'hCAFE_F00D;
    i_addr = 32'h500; i_req = 1; mode_i = 1;
    wait_ack(0, 40, "t5");
    chk("t5_err", {63'd0, i_err}, 64'd0);
    chk("t5_rdata", {32'd0, i_rdata}, 64'hCAFE_F00D);
    step(); step();

    // stray mem_ack while idle
    lat_en = 0;
    #1 mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step(); step();
    chk("t6_no_acks", {62'd0, i_ack, d_ack}, 64'd0);
    chk("t6_idle", {63'd0, mem_req}, 64'd0);

    // async reset in the middle of a busy period
    i_addr = 32'h600; i_req = 1; mode_i = 1;
    step(); step(); step();
    chk("t7_busy", {63'd0, mem_req}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_mem_req", {63'd0, mem_req}, 64'd0);
    chk("t7_async_acks", {62'd0, i_ack, d_ack}, 64'd0);
    step(); rst = 1'b0;
    step();
    chk("t7_regrant", {63'd0, mem_req}, 64'd1);
    chk("t7_regrant_addr", {32'd0, mem_addr}, 64'h600);
    lat_en = 1; mem_lat = 0; rdata_val = 32'h1111_2222;
    wait_ack(0, 20, "t7");
    chk("t7_rdata", {32'd0, i_rdata}, 64'h1111_2222);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
